pcie_rr_dispatcher: RTL and testbench

- Parametrised round-robin dispatcher for the transaction layer.
- Pops words from one upstream FIFO and pushes each word into exactly one of NUM_CH downstream FIFOs.
- Per-channel backpressure: a channel whose FIFO is almost full is skipped or waited on, and the other channels are not stalled.
- Sits between the shared ingress FIFO and the per-virtual-channel FIFOs, replacing the fixed 4-channel referee.

---
 rtl/pcie_rr_dispatcher.sv | 130 +++++++++++++
 tb/tb_pcie_rr_dispatcher.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rr_dispatcher.sv
// Round-robin dispatcher: moves one word at a time from the shared ingress FIFO into one of NUM_CH
// per-channel FIFOs. Define PCIE_RR_DISPATCH_STRICT_EN for strict in-order channel rotation.
module pcie_rr_dispatcher #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 12,
  parameter int EXTRA_GAP = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      fifo_empty,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [NUM_CH-1:0]         almost_full,
  output logic                      pop,
  output logic [NUM_CH-1:0]         push,
  output logic [DATA_W-1:0]         data_out,
  output logic [$clog2(NUM_CH)-1:0] last_ch,
  output logic                      busy
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W:0] NUM_CH_EXT = (CH_W+1)'(NUM_CH);
  localparam logic [3:0] GAP_LOAD = (EXTRA_GAP > 0) ? 4'(EXTRA_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {ARB, POP, CAP, GAP} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [3:0]          gap_q, gap_d;
  logic                pop_d;
  logic [NUM_CH-1:0]   push_d;
  logic [DATA_W-1:0]   data_d;
  logic [CH_W-1:0]     last_d;

  logic [NUM_CH-1:0]   eligible;
  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [CH_W-1:0]     off;
  logic [CH_W:0]       sum;
  logic [CH_W-1:0]     sel;
  logic                any_eligible;

  always_comb begin
    eligible = '0;
`ifdef PCIE_RR_DISPATCH_STRICT_EN
    eligible[ptr_q] = ~almost_full[ptr_q];
`else
    eligible = ~almost_full;
`endif
  end

  // Rotate so bit 0 is channel ptr, take the lowest set bit, then map the offset back modulo NUM_CH.
  always_comb begin
    dbl = {eligible, eligible} >> ptr_q;
    rot = dbl[NUM_CH-1:0];
    off = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (rot[j]) off = CH_W'(j);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= NUM_CH_EXT) sum = sum - NUM_CH_EXT;
    sel = sum[CH_W-1:0];
    any_eligible = |rot;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    pop_d   = 1'b0;
    push_d  = '0;
    data_d  = data_out;
    last_d  = last_ch;
    case (state_q)
      ARB: begin
        if (enable && !fifo_empty && any_eligible) begin
          grant_d = sel;
          pop_d   = 1'b1;
          state_d = POP;
        end
      end
      POP: state_d = CAP;
      CAP: begin
        data_d = data_in;
        push_d = NUM_CH'(1) << grant_q;
        last_d = grant_q;
        ptr_d  = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
        if (EXTRA_GAP > 0) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = ARB;
        end
      end
      GAP: begin
        if (gap_q == 4'd0) state_d = ARB;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = ARB;
    endcase
  end

  // A reset mid-word simply drops the word; it was already taken from the upstream FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      grant_q  <= '0;
      gap_q    <= '0;
      pop      <= 1'b0;
      push     <= '0;
      data_out <= '0;
      last_ch  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      gap_q    <= gap_d;
      pop      <= pop_d;
      push     <= push_d;
      data_out <= data_d;
      last_ch  <= last_d;
    end
  end

  assign busy = (state_q != ARB);

endmodule

// File: tb/tb_pcie_rr_dispatcher.sv
// Bench for pcie_rr_dispatcher: two instances (4 ch / no gap, 3 ch / gap 2) checked every cycle
// against a transaction-timing model of the upstream FIFO and channel rotation.
module tb_pcie_rr_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        en [2];
  logic        fe [2];
  logic [11:0] din [2];
  logic [7:0]  af [2];

  logic        pop0, pop1, busy0, busy1;
  logic [3:0]  push0;
  logic [2:0]  push1;
  logic [11:0] do0, do1;
  logic [1:0]  lc0, lc1;

  always #5 clk = ~clk;

  pcie_rr_dispatcher #(.NUM_CH(4), .DATA_W(12), .EXTRA_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .enable(en[0]), .fifo_empty(fe[0]), .data_in(din[0]),
    .almost_full(af[0][3:0]), .pop(pop0), .push(push0), .data_out(do0), .last_ch(lc0), .busy(busy0)
  );

  pcie_rr_dispatcher #(.NUM_CH(3), .DATA_W(12), .EXTRA_GAP(2)) dut1 (
    .clk(clk), .reset(reset), .enable(en[1]), .fifo_empty(fe[1]), .data_in(din[1]),
    .almost_full(af[1][2:0]), .pop(pop1), .push(push1), .data_out(do1), .last_ch(lc1), .busy(busy1)
  );

  int nch [2] = '{4, 3};
  int gap [2] = '{0, 2};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: one word in flight, decided in cycle k, pop at k+1, push at k+3, next decision at k+3+gap.
  int          mptr [2], pop_cyc [2], push_cyc [2], dec_cyc [2], next_arb [2], mch [2];
  logic [11:0] mword [2], exp_data [2];
  int          exp_last [2];

  logic [11:0] qmem [2][256];
  int          qhead [2], qcnt [2];
  int          plog [2][64], plog_n [2];
  int          poplog [2][64], poplog_n [2];

  logic        tgt_reset, rand_mode;
  logic        tgt_en [2], tgt_fe [2];
  logic [7:0]  tgt_af [2];

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mptr[i] = 0; pop_cyc[i] = -100; push_cyc[i] = -100; dec_cyc[i] = -100;
      next_arb[i] = 0; mch[i] = 0; mword[i] = '0; exp_data[i] = '0; exp_last[i] = 0;
    end
  endtask

  task automatic clearLogs();
    for (int i = 0; i < 2; i++) begin
      plog_n[i] = 0; poplog_n[i] = 0;
    end
  endtask

  task automatic loadWords(input int i, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      qmem[i][(qhead[i] + qcnt[i]) % 256] = 12'(first + k);
      qcnt[i]++;
    end
  endtask

  function automatic int pick(input int i);
`ifdef PCIE_RR_DISPATCH_STRICT_EN
    return af[i][mptr[i]] ? -1 : mptr[i];
`else
    for (int s = 0; s < nch[i]; s++) begin
      int c;
      c = (mptr[i] + s) % nch[i];
      if (!af[i][c]) return c;
    end
    return -1;
`endif
  endfunction

  task automatic applyStimulus();
    if (reset && !tgt_reset) reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic force_empty;
      int   c;
      if (rand_mode) begin
        en[i] = ($urandom_range(9) != 0);
        af[i] = 8'($urandom) & 8'($urandom);
        if ($urandom_range(3) == 0 && qcnt[i] < 200) loadWords(i, int'($urandom_range(4095)), 1);
        force_empty = ($urandom_range(9) == 0);
      end else begin
        en[i] = tgt_en[i];
        af[i] = tgt_af[i];
        force_empty = tgt_fe[i];
      end
      fe[i]  = force_empty || (qcnt[i] == 0);
      din[i] = (cyc == push_cyc[i] - 1) ? mword[i] : 12'($urandom);
      if (!reset && cyc >= next_arb[i] && en[i] && !fe[i]) begin
        c = pick(i);
        if (c >= 0) begin
          dec_cyc[i]  = cyc;
          pop_cyc[i]  = cyc + 1;
          push_cyc[i] = cyc + 3;
          next_arb[i] = cyc + 3 + gap[i];
          mch[i]      = c;
          mword[i]    = qmem[i][qhead[i]];
          qhead[i]    = (qhead[i] + 1) % 256;
          qcnt[i]--;
          mptr[i]     = (c + 1) % nch[i];
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic        o_pop, o_busy, e_pop, e_busy;
    logic [7:0]  o_push, e_push;
    logic [11:0] o_data;
    logic [1:0]  o_lc;
    for (int i = 0; i < 2; i++) begin
      o_pop  = (i == 0) ? pop0  : pop1;
      o_busy = (i == 0) ? busy0 : busy1;
      o_push = (i == 0) ? 8'(push0) : 8'(push1);
      o_data = (i == 0) ? do0 : do1;
      o_lc   = (i == 0) ? lc0 : lc1;
      e_push = 8'h00;
      if (cyc == push_cyc[i]) begin
        e_push      = 8'h01 << mch[i];
        exp_data[i] = mword[i];
        exp_last[i] = mch[i];
        if (plog_n[i] < 64) plog[i][plog_n[i]] = mch[i];
        plog_n[i]++;
      end
      e_pop  = (cyc == pop_cyc[i]);
      e_busy = (cyc > dec_cyc[i]) && (cyc < next_arb[i]);
      check("pop", i, 32'(o_pop), 32'(e_pop));
      check("push", i, 32'(o_push), 32'(e_push));
      check("data_out", i, 32'(o_data), 32'(exp_data[i]));
      check("last_ch", i, 32'(o_lc), exp_last[i]);
      check("busy", i, 32'(o_busy), 32'(e_busy));
      if (o_pop === 1'b1) begin
        if (poplog_n[i] < 64) poplog[i][poplog_n[i]] = cyc;
        poplog_n[i]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
    applyStimulus();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int  n0, exp0, exp1;
    logic found;
    reset = 1'b1; tgt_reset = 1'b1; rand_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; tgt_en[i] = 1'b0; af[i] = '0; tgt_af[i] = '0;
      fe[i] = 1'b1; tgt_fe[i] = 1'b0; din[i] = '0; qhead[i] = 0; qcnt[i] = 0;
    end
    modelReset();
    clearLogs();
    run(3);

    $display("[TB] basic rotation / gap and wrap");
    tgt_reset = 1'b0; tgt_en[0] = 1'b1; tgt_en[1] = 1'b1;
    loadWords(0, 1, 8);
    loadWords(1, 1, 5);
    run(40);
    check("basic_count", 0, plog_n[0], 8);
    for (int j = 0; j < 8; j++) check("basic_order", 0, plog[0][j], j % 4);
    for (int j = 0; j < 7; j++) check("basic_pop_gap", 0, poplog[0][j+1] - poplog[0][j], 3);
    check("wrap_count", 1, plog_n[1], 5);
    for (int j = 0; j < 5; j++) check("wrap_order", 1, plog[1][j], j % 3);
    for (int j = 0; j < 4; j++) check("wrap_pop_gap", 1, poplog[1][j+1] - poplog[1][j], 5);
    check("wrap_last_ch", 1, 32'(lc1), 1);

    $display("[TB] skip almost-full channel");
    clearLogs();
    tgt_af[0] = 8'h02;
    loadWords(0, 12'h010, 4);
    run(20);
`ifdef PCIE_RR_DISPATCH_STRICT_EN
    check("strict_count", 0, plog_n[0], 1);
    check("strict_first", 0, plog[0][0], 0);
`else
    check("skip_count", 0, plog_n[0], 4);
    check("skip_order0", 0, plog[0][0], 0);
    check("skip_order1", 0, plog[0][1], 2);
    check("skip_order2", 0, plog[0][2], 3);
    check("skip_order3", 0, plog[0][3], 0);
`endif
    tgt_af[0] = 8'h00;
    run(20);

    $display("[TB] all channels almost full");
    clearLogs();
    tgt_af[0] = 8'hFF; tgt_af[1] = 8'hFF;
    loadWords(0, 12'h020, 4);
    loadWords(1, 12'h030, 3);
    exp0 = mptr[0]; exp1 = mptr[1];
    run(20);
    check("full_no_push", 0, plog_n[0], 0);
    check("full_no_push", 1, plog_n[1], 0);
    check("full_no_pop", 0, poplog_n[0], 0);
    tgt_af[0] = 8'h00; tgt_af[1] = 8'h00;
    run(25);
    check("full_resume_ch", 0, plog[0][0], exp0);
    check("full_resume_ch", 1, plog[1][0], exp1);

    $display("[TB] upstream empty");
    clearLogs();
    tgt_fe[0] = 1'b1; tgt_fe[1] = 1'b1;
    loadWords(0, 12'h040, 3);
    loadWords(1, 12'h050, 3);
    run(20);
    check("empty_no_push", 0, plog_n[0], 0);
    check("empty_no_push", 1, plog_n[1], 0);
    tgt_fe[0] = 1'b0; tgt_fe[1] = 1'b0;
    run(25);
    check("empty_resume", 0, plog_n[0], 3);
    check("empty_resume", 1, plog_n[1], 3);

    $display("[TB] enable dropped in POP");
    clearLogs();
    loadWords(0, 12'h060, 3);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (pop_cyc[0] == cyc + 1) found = 1'b1;
    end
    check("en_find_grant", 0, 32'(found), 1);
    tgt_en[0] = 1'b0;
    n0 = plog_n[0];
    run(12);
    check("en_drop_one_push", 0, plog_n[0], n0 + 1);
    tgt_en[0] = 1'b1;
    run(20);

    $display("[TB] reset during CAP");
    clearLogs();
    loadWords(0, 12'h070, 2);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (cyc == push_cyc[0] - 1) found = 1'b1;
    end
    check("rst_find_cap", 0, 32'(found), 1);
    reset = 1'b1; tgt_reset = 1'b1;
    modelReset();
    #1;
    checkOutput();
    n0 = plog_n[0];
    run(3);
    tgt_reset = 1'b0;
    run(20);
    check("rst_after_count", 0, plog_n[0], n0 + 1);
    check("rst_after_ch", 0, plog[0][n0], 0);

    $display("[TB] randomized traffic");
    rand_mode = 1'b1;
    run(400);
    rand_mode = 1'b0;
    tgt_af[0] = 8'h00; tgt_af[1] = 8'h00;
    tgt_en[0] = 1'b1; tgt_en[1] = 1'b1;
    tgt_fe[0] = 1'b0; tgt_fe[1] = 1'b0;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
